// File: rtl/dcache_ctrl_if.sv
// Bundle of CPU, cache-SRAM and main-memory signals around dcache_ctrl.
// slave = the controller's view; master = the surrounding CPU/SRAM/memory side.
interface dcache_ctrl_if;
  // CPU MEM stage
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic         cpu_MemRead_i;
  logic         cpu_MemWrite_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  // Cache SRAM
  logic         sram_hit_i;
  logic [24:0]  sram_tag_i;
  logic [255:0] sram_data_i;
  logic [3:0]   cache_sram_index_o;
  logic [24:0]  cache_sram_tag_o;
  logic [255:0] cache_sram_data_o;
  logic         cache_sram_enable_o;
  logic         cache_sram_write_o;
  // Main memory
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  modport slave (
    input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
    output cpu_data_o, cpu_stall_o,
    input  sram_hit_i, sram_tag_i, sram_data_i,
    output cache_sram_index_o, cache_sram_tag_o, cache_sram_data_o,
    output cache_sram_enable_o, cache_sram_write_o,
    output mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
    input  mem_data_i, mem_ack_i
  );

  modport master (
    output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
    input  cpu_data_o, cpu_stall_o,
    output sram_hit_i, sram_tag_i, sram_data_i,
    input  cache_sram_index_o, cache_sram_tag_o, cache_sram_data_o,
    input  cache_sram_enable_o, cache_sram_write_o,
    input  mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
    output mem_data_i, mem_ack_i
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate controller for a 16-set, 32-byte-line cache.
// Define DCACHE_CTRL_PERF_CNT_EN to add saturating hit/miss counters.
module dcache_ctrl (
  input  logic          clk_i,
  input  logic          rst_i,
  dcache_ctrl_if.slave  bus
`ifdef DCACHE_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]   hit_cnt_o,
  output logic [31:0]   miss_cnt_o
`endif
);

  typedef enum logic [2:0] {
    StIdle, StMiss, StWriteback, StReadMiss, StReadMissOk
  } state_e;

  state_e       state_q, state_d;
  logic         mem_enable_q, mem_enable_d;
  logic         mem_write_q, mem_write_d;
  logic [31:0]  mem_addr_q, mem_addr_d;
  logic [255:0] mem_data_q, mem_data_d;

  logic         req;
  logic         idle_hit;
  logic         victim_dirty;
  logic [2:0]   word_sel;
  logic [3:0]   index;
  logic [22:0]  cpu_tag;
  logic [31:0]  fetch_addr;
  logic         unused_addr_bits;

  assign req          = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
  assign word_sel     = bus.cpu_addr_i[4:2];
  assign index        = bus.cpu_addr_i[8:5];
  assign cpu_tag      = bus.cpu_addr_i[31:9];
  assign fetch_addr   = {bus.cpu_addr_i[31:5], 5'b0};
  assign idle_hit     = (state_q == StIdle) & bus.sram_hit_i;
  assign victim_dirty = bus.sram_tag_i[24] & bus.sram_tag_i[23];
  assign unused_addr_bits = ^bus.cpu_addr_i[1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    unique case (state_q)
      StIdle: begin
        if (req && !bus.sram_hit_i) state_d = StMiss;
      end
      StMiss: begin
        mem_enable_d = 1'b1;
        if (victim_dirty) begin
          mem_write_d = 1'b1;
          mem_addr_d  = {bus.sram_tag_i[22:0], index, 5'b0};
          mem_data_d  = bus.sram_data_i;
          state_d     = StWriteback;
        end else begin
          mem_write_d = 1'b0;
          mem_addr_d  = fetch_addr;
          state_d     = StReadMiss;
        end
      end
      StWriteback: begin
        // Chain straight into the refill fetch with no idle cycle.
        if (bus.mem_ack_i) begin
          mem_write_d = 1'b0;
          mem_addr_d  = fetch_addr;
          state_d     = StReadMiss;
        end
      end
      StReadMiss: begin
        if (bus.mem_ack_i) begin
          mem_enable_d = 1'b0;
          state_d      = StReadMissOk;
        end
      end
      StReadMissOk: state_d = StIdle;
      default:      state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.cpu_data_o          = '0;
    bus.cpu_stall_o         = req & ~idle_hit;
    bus.cache_sram_enable_o = req;
    bus.cache_sram_index_o  = index;
    bus.cache_sram_tag_o    = {1'b1, 1'b0, cpu_tag};
    bus.cache_sram_data_o   = bus.sram_data_i;
    bus.cache_sram_write_o  = 1'b0;
    if (idle_hit) begin
      bus.cpu_data_o = bus.sram_data_i[{word_sel, 5'b0} +: 32];
    end
    if (idle_hit && bus.cpu_MemWrite_i) begin
      bus.cache_sram_write_o                          = 1'b1;
      bus.cache_sram_tag_o                            = {1'b1, 1'b1, cpu_tag};
      bus.cache_sram_data_o[{word_sel, 5'b0} +: 32]   = bus.cpu_data_i;
    end else if ((state_q == StReadMiss) && bus.mem_ack_i) begin
      bus.cache_sram_write_o = 1'b1;
      bus.cache_sram_data_o  = bus.mem_data_i;
    end
  end

  assign bus.mem_enable_o = mem_enable_q;
  assign bus.mem_write_o  = mem_write_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_data_o   = mem_data_q;

`ifdef DCACHE_CTRL_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        after_refill_q;
  logic        hit_inc, miss_inc;

  // The retry hit that completes a refill is part of the miss, not a hit.
  assign hit_inc  = idle_hit & req & ~after_refill_q;
  assign miss_inc = (state_q == StIdle) & req & ~bus.sram_hit_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q      <= '0;
      miss_cnt_q     <= '0;
      after_refill_q <= 1'b0;
    end else begin
      after_refill_q <= (state_q == StReadMissOk);
      if (hit_inc && (hit_cnt_q != 32'hFFFF_FFFF))   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_inc && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
